irq_capture_wb: RTL and testbench

- Wishbone slave interrupt aggregator, placed between the debounced pushbutton, timer-tick and UART-receive event lines and the CPU `interrupt` input.
- Synchronises each raw source and captures it as a sticky pending bit, edge- or level-triggered per source.
- Applies a per-source enable mask and presents the masked vector plus a combined request to the core.
- Occupies one intercon slave slot; firmware reads and clears pending bits over the bus.

---
 rtl/irq_capture_wb_if.sv | 26 ++
 rtl/irq_capture_wb.sv | 117 +++++++++++
 tb/tb_irq_capture_wb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_capture_wb_if.sv
// Wishbone classic bus bundle between the intercon master and the interrupt aggregator slave.
interface irq_capture_wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_w;
  logic [DW-1:0] wb_dat_r;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_cyc;
  logic          wb_ack;
  logic          wb_err;
  logic          wb_rty;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_stb, wb_cyc,
    input  wb_dat_r, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_stb, wb_cyc,
    output wb_dat_r, wb_ack, wb_err, wb_rty
  );
endinterface

// File: rtl/irq_capture_wb.sv
// Wishbone interrupt aggregator: synchronises raw sources into sticky pending bits (edge or level),
// masks them with ENABLE and drives a registered combined request to the CPU.
module irq_capture_wb #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  irq_capture_wb_if.slave    wb,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic [NUM_IRQ-1:0] irq_vec_o,
  output logic               irq_o
);
  localparam logic [2:0] AdrPending = 3'd0;
  localparam logic [2:0] AdrEnable  = 3'd1;
  localparam logic [2:0] AdrEdge    = 3'd2;
  localparam logic [2:0] AdrStatus  = 3'd3;
  localparam logic [2:0] AdrSet     = 3'd4;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] s1_q, s2_q, hist_q;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               irq_q, irq_d;
  logic [DW-1:0]      dat_q, dat_d;

  logic [AW-1:0]      adr_full;
  logic [DW-1:0]      wdat_full;
  logic [31:0]        sel_mask;
  logic [NUM_IRQ-1:0] wmask, wdat, hw_set, sw_set, sw_clr;
  logic [2:0]         adr;
  logic               req, mapped;
  logic               unused_ok;

  assign adr_full  = wb.wb_adr;
  assign wdat_full = wb.wb_dat_w;
  assign sel_mask  = {{8{wb.wb_sel[3]}}, {8{wb.wb_sel[2]}}, {8{wb.wb_sel[1]}}, {8{wb.wb_sel[0]}}};
  assign wmask     = sel_mask[NUM_IRQ-1:0];
  assign wdat      = wdat_full[NUM_IRQ-1:0];
  assign adr       = adr_full[4:2];
  assign mapped    = (adr <= AdrSet);
  assign req       = wb.wb_cyc & wb.wb_stb & ~ack_q & ~err_q;
  assign unused_ok = ^{adr_full, wdat_full, sel_mask};

  // Edge mode fires only on a 0->1 step of the synchronised source; level mode fires while high.
  assign hw_set = s2_q & ~(edge_q & hist_q);

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    sw_set   = '0;
    sw_clr   = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = '0;
    if (req) begin
      ack_d = mapped;
      err_d = ~mapped;
      if (!wb.wb_we) begin
        case (adr)
          AdrPending: dat_d[NUM_IRQ-1:0] = pending_q;
          AdrEnable:  dat_d[NUM_IRQ-1:0] = enable_q;
          AdrEdge:    dat_d[NUM_IRQ-1:0] = edge_q;
          AdrStatus:  dat_d[NUM_IRQ-1:0] = pending_q & enable_q;
          default:    dat_d = '0;
        endcase
      end else begin
        case (adr)
          AdrPending: sw_clr = wdat & wmask;
          AdrEnable:  enable_d = (enable_q & ~wmask) | (wdat & wmask);
          AdrEdge:    edge_d = (edge_q & ~wmask) | (wdat & wmask);
          AdrSet:     sw_set = wdat & wmask;
          default:    ;
        endcase
      end
    end
    // Sets are ORed in after the clear so a coincident event is never lost.
    pending_d = (pending_q & ~sw_clr) | hw_set | sw_set;
    irq_d     = |(pending_q & enable_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '1;
      s1_q      <= '0;
      s2_q      <= '0;
      hist_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      s1_q      <= irq_src_i;
      s2_q      <= s1_q;
      hist_q    <= s2_q;
      ack_q     <= ack_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      dat_q     <= dat_d;
    end
  end

  assign irq_vec_o   = pending_q & enable_q;
  assign irq_o       = irq_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign wb.wb_rty   = 1'b0;
  assign wb.wb_dat_r = dat_q;
endmodule

// File: tb/tb_irq_capture_wb.sv
// Scoreboarded bench for irq_capture_wb: bus tasks queue expected terminations and read data,
// a negedge monitor pops and compares them whenever the slave acks or errors.
module tb_irq_capture_wb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = '0;
  logic [7:0] vec;
  logic       irq;

  always #5 clk = ~clk;

  irq_capture_wb_if #(.AW(32), .DW(32)) bus ();

  irq_capture_wb #(.NUM_IRQ(8), .AW(32), .DW(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb        (bus.slave),
    .irq_src_i (src),
    .irq_vec_o (vec),
    .irq_o     (irq)
  );

  typedef struct {
    string       tag;
    logic        rd;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_ack || bus.wb_err) begin
      if (sb.size() == 0) begin
        check("spurious_term", 32'({bus.wb_ack, bus.wb_err}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "/term"}, 32'({bus.wb_ack, bus.wb_err}),
              mon_e.err ? 32'd1 : 32'd2);
        if (mon_e.rd) check({mon_e.tag, "/data"}, bus.wb_dat_r, mon_e.dat);
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                         input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    e.tag = tag;
    e.rd  = ~we;
    e.err = exp_err;
    e.dat = exp_dat;
    sb.push_back(e);
    bus.wb_adr   = adr;
    bus.wb_dat_w = dat;
    bus.wb_sel   = sel;
    bus.wb_we    = we;
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.wb_ack || bus.wb_err) && n < 4);
    check({tag, "/latency"}, 32'(n), 32'd1);
    if (!(bus.wb_ack || bus.wb_err)) void'(sb.pop_back());
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input string tag);
    wb_xfer(adr, 1'b1, dat, sel, 1'b0, 32'd0, tag);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    wb_xfer(adr, 1'b0, 32'd0, 4'hf, 1'b0, exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, max_run, highs;
    bus.wb_adr = '0; bus.wb_dat_w = '0; bus.wb_sel = '0;
    bus.wb_we = 1'b0; bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    wb_rd(32'h00, 32'h00, "rst_pending");
    wb_rd(32'h04, 32'h00, "rst_enable");
    wb_rd(32'h08, 32'hFF, "rst_edge");
    wb_rd(32'h0C, 32'h00, "rst_status");
    check("rst_irq", 32'(irq), 32'd0);

    // Edge capture latency and W1C
    wb_wr(32'h04, 32'h01, 4'hf, "en_01");
    wb_wr(32'h08, 32'h01, 4'hf, "edge_01");
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); check("edge_vec_e1", 32'(vec), 32'h00);
    @(negedge clk); check("edge_vec_e2", 32'(vec), 32'h01);
    check("edge_irq_e2", 32'(irq), 32'd0);
    @(negedge clk); check("edge_irq_e3", 32'(irq), 32'd1);
    wb_wr(32'h00, 32'h01, 4'hf, "w1c_edge");
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (irq) highs++;
    end
    check("w1c_edge_irq_low", 32'(highs), 32'd0);
    wb_rd(32'h00, 32'h00, "w1c_edge_pending");
    src[0] = 1'b0;

    // Level capture re-asserts after clear
    wb_wr(32'h08, 32'h00, 4'hf, "edge_00");
    wb_wr(32'h04, 32'h02, 4'hf, "en_02");
    src[1] = 1'b1;
    repeat (4) @(negedge clk);
    wb_wr(32'h00, 32'h02, 4'hf, "w1c_level");
    run = 0; max_run = 0;
    repeat (6) begin
      @(negedge clk);
      run = irq ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    check("level_irq_low_run_le2", 32'(max_run > 2), 32'd0);
    wb_rd(32'h00, 32'h02, "level_repend");
    src[1] = 1'b0;
    repeat (4) @(negedge clk);
    wb_wr(32'h00, 32'h02, 4'hf, "w1c_level2");
    wb_rd(32'h00, 32'h00, "level_cleared");

    // W1C landing on the same edge as an edge set
    wb_wr(32'h08, 32'h01, 4'hf, "edge_01b");
    wb_wr(32'h04, 32'h00, 4'hf, "en_00");
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk);
    wb_wr(32'h00, 32'h01, 4'hf, "w1c_collide");
    wb_rd(32'h00, 32'h01, "collide_pending");
    src[0] = 1'b0;
    wb_wr(32'h00, 32'h01, 4'hf, "w1c_after");
    wb_rd(32'h00, 32'h00, "collide_cleared");

    // Software set with byte lanes, masking and re-enable
    wb_wr(32'h10, 32'hA5, 4'b0010, "set_lane1");
    wb_rd(32'h00, 32'h00, "set_lane1_pending");
    wb_wr(32'h10, 32'hA5, 4'b0001, "set_lane0");
    wb_rd(32'h00, 32'hA5, "set_pending");
    wb_rd(32'h0C, 32'h00, "set_status");
    check("set_irq", 32'(irq), 32'd0);
    wb_wr(32'h0C, 32'hFF, 4'hf, "status_wr");
    wb_rd(32'h0C, 32'h00, "status_ro");
    wb_rd(32'h10, 32'h00, "set_reads_zero");
    wb_wr(32'h04, 32'h80, 4'hf, "en_80");
    check("reen_vec", 32'(vec), 32'h80);
    check("reen_irq_ack", 32'(irq), 32'd0);
    @(negedge clk); check("reen_irq_next", 32'(irq), 32'd1);
    wb_rd(32'h0C, 32'h80, "reen_status");

    // Unmapped offsets
    wb_xfer(32'h18, 1'b0, 32'd0, 4'hf, 1'b1, 32'd0, "rd_unmapped");
    wb_xfer(32'h14, 1'b1, 32'hFF, 4'hf, 1'b1, 32'd0, "wr_unmapped");
    wb_rd(32'h00, 32'hA5, "unmapped_no_effect");

    // Reset in the middle of a transfer
    @(negedge clk);
    bus.wb_adr = 32'h00; bus.wb_we = 1'b0; bus.wb_sel = 4'hf;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(bus.wb_ack), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_vec", 32'(vec), 32'd0);
    check("mid_rst_pending", 32'(dut.pending_q), 32'd0);
    check("mid_rst_enable", 32'(dut.enable_q), 32'd0);
    check("mid_rst_edge", 32'(dut.edge_q), 32'hFF);
    repeat (2) @(negedge clk);
    check("mid_rst_no_ack", 32'({bus.wb_ack, bus.wb_err}), 32'd0);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    rst = 1'b0;
    wb_rd(32'h08, 32'hFF, "post_rst_edge");
    wb_rd(32'h00, 32'h00, "post_rst_pending");

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
